// File: rtl/issue_queue.sv
// In-order issue queue between ID and IS: a circular FIFO of decoded micro-ops.
// A branch-taken or hazard flush (kill) discards every buffered wrong-path entry.
module issue_queue #(
  parameter int DATA_WD = 212,
  parameter int DEPTH   = 8,
  parameter int PTR_WD  = 3,
  parameter int BR_BUS  = 33
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BR_BUS-1:0]  br_bus,
  input  logic               ds_flush,
  input  logic               ds_stall,
  input  logic               ds_to_is_valid,
  input  logic [DATA_WD-1:0] ds_to_is_bus,
  output logic               IQ_allowin,
  input  logic               is_allowin,
  output logic               iq_to_is_valid,
  output logic [DATA_WD-1:0] iq_to_is_bus,
  output logic [PTR_WD:0]    iq_count
);

  localparam logic [PTR_WD:0] FULL_CNT = (PTR_WD + 1)'(DEPTH);

  logic [DATA_WD-1:0] mem [DEPTH];
  logic [PTR_WD-1:0]  rd_ptr;
  logic [PTR_WD-1:0]  wr_ptr;
  logic [PTR_WD:0]    count;

  logic kill;
  logic enq;
  logic deq;

  // Only the taken bit of the branch bus matters here; the target is IF's concern.
  logic unused_br_target;
  assign unused_br_target = ^br_bus[BR_BUS-2:0];

  assign kill           = ds_flush | br_bus[BR_BUS-1];
  // Full/empty come from registered count only, so no is_allowin -> IQ_allowin path.
  assign IQ_allowin     = (count != FULL_CNT);
  assign iq_to_is_valid = (count != '0);
  assign enq            = ds_to_is_valid & IQ_allowin & ~ds_stall & ~kill;
  assign deq            = iq_to_is_valid & is_allowin & ~kill;

  assign iq_to_is_bus   = iq_to_is_valid ? mem[rd_ptr] : '0;
  assign iq_count       = count;

  // NOTE: the payload array has no reset; validity is tracked by count alone,
  // so clearing the entries would only add reset fan-out for no behavioural gain.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= ds_to_is_bus;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || kill) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_WD'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_WD'(1);
      unique case ({enq, deq})
        2'b10:   count <= count + (PTR_WD + 1)'(1);
        2'b01:   count <= count - (PTR_WD + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed test-plan steps followed by a
// randomized phase, all compared against a queue-based reference model.
module tb_issue_queue;

  localparam int DATA_WD = 212;
  localparam int DEPTH   = 8;
  localparam int PTR_WD  = 3;
  localparam int BR_BUS  = 33;

  logic               clk;
  logic               reset;
  logic [BR_BUS-1:0]  br_bus;
  logic               ds_flush;
  logic               ds_stall;
  logic               ds_to_is_valid;
  logic [DATA_WD-1:0] ds_to_is_bus;
  logic               IQ_allowin;
  logic               is_allowin;
  logic               iq_to_is_valid;
  logic [DATA_WD-1:0] iq_to_is_bus;
  logic [PTR_WD:0]    iq_count;

  int checks = 0;
  int errors = 0;

  // Reference model: contents of the queue, oldest first.
  logic [DATA_WD-1:0] model_q [$];

  issue_queue #(
    .DATA_WD(DATA_WD), .DEPTH(DEPTH), .PTR_WD(PTR_WD), .BR_BUS(BR_BUS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .br_bus(br_bus),
    .ds_flush(ds_flush),
    .ds_stall(ds_stall),
    .ds_to_is_valid(ds_to_is_valid),
    .ds_to_is_bus(ds_to_is_bus),
    .IQ_allowin(IQ_allowin),
    .is_allowin(is_allowin),
    .iq_to_is_valid(iq_to_is_valid),
    .iq_to_is_bus(iq_to_is_bus),
    .iq_count(iq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_WD-1:0] obs,
                       input logic [DATA_WD-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [DATA_WD-1:0] exp_bus;
    exp_bus = (model_q.size() != 0) ? model_q[0] : '0;
    check("allowin", DATA_WD'(IQ_allowin), DATA_WD'(model_q.size() != DEPTH));
    check("valid",   DATA_WD'(iq_to_is_valid), DATA_WD'(model_q.size() != 0));
    check("count",   DATA_WD'(iq_count), DATA_WD'(model_q.size()));
    check("head",    iq_to_is_bus, exp_bus);
  endtask

  // One clock cycle: drive inputs at the falling edge, compare state-only
  // outputs against the model, then advance the model at the rising edge.
  task automatic cycle(input logic v, input logic [DATA_WD-1:0] d,
                       input logic st, input logic fl, input logic br,
                       input logic ia, input logic rst);
    int  sz;
    bit  do_enq;
    bit  do_deq;
    ds_to_is_valid = v;
    ds_to_is_bus   = d;
    ds_stall       = st;
    ds_flush       = fl;
    br_bus         = {br, 32'($urandom)};
    is_allowin     = ia;
    reset          = rst;
    check_model();
    @(posedge clk);
    sz = model_q.size();
    if (rst || fl || br) begin
      model_q.delete();
    end else begin
      do_enq = v && (sz < DEPTH) && !st;
      do_deq = (sz > 0) && ia;
      if (do_deq) void'(model_q.pop_front());
      if (do_enq) model_q.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic push(input logic [DATA_WD-1:0] d);
    cycle(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [DATA_WD-1:0] rnd;

    reset          = 1'b1;
    br_bus         = '0;
    ds_flush       = 1'b0;
    ds_stall       = 1'b0;
    ds_to_is_valid = 1'b0;
    ds_to_is_bus   = '0;
    is_allowin     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset values
    check("rst_allowin", DATA_WD'(IQ_allowin), DATA_WD'(1));
    check("rst_valid",   DATA_WD'(iq_to_is_valid), '0);
    check("rst_bus",     iq_to_is_bus, '0);
    check("rst_count",   DATA_WD'(iq_count), '0);

    // Fill and drain
    for (int i = 1; i <= 8; i++) push(DATA_WD'(i));
    check("fill_allowin", DATA_WD'(IQ_allowin), '0);
    check("fill_count",   DATA_WD'(iq_count), DATA_WD'(8));
    for (int i = 1; i <= 8; i++) begin
      check("drain_order", iq_to_is_bus, DATA_WD'(i));
      pop();
    end
    check("drain_valid", DATA_WD'(iq_to_is_valid), '0);
    check("drain_count", DATA_WD'(iq_count), '0);

    // Stall hold: one entry despite four cycles of valid
    repeat (3) cycle(1'b1, DATA_WD'('hA5), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, DATA_WD'('hA5), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("stall_count", DATA_WD'(iq_count), DATA_WD'(1));
    check("stall_head",  iq_to_is_bus, DATA_WD'('hA5));
    pop();

    // Branch flush with an in-flight entry and a ready IS stage
    for (int i = 0; i < 5; i++) push(DATA_WD'('h20 + i));
    cycle(1'b1, DATA_WD'('hEE), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("flush_count",   DATA_WD'(iq_count), '0);
    check("flush_valid",   DATA_WD'(iq_to_is_valid), '0);
    check("flush_allowin", DATA_WD'(IQ_allowin), DATA_WD'(1));
    pop();
    check("flush_no_inflight", DATA_WD'(iq_count), '0);

    // Full queue: dequeue only, then sustained push/pop across pointer wrap
    for (int i = 1; i <= 8; i++) push(DATA_WD'('h40 + i));
    cycle(1'b1, DATA_WD'('h50), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("full_allowin", DATA_WD'(IQ_allowin), DATA_WD'(1));
    check("full_count",   DATA_WD'(iq_count), DATA_WD'(7));
    check("full_head",    iq_to_is_bus, DATA_WD'('h42));
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, DATA_WD'('h60 + i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("stream_count", DATA_WD'(iq_count), DATA_WD'(7));
    end
    check("stream_head", iq_to_is_bus, DATA_WD'('h65));
    repeat (7) pop();

    // Empty pass-through: no bypass, one cycle of visibility
    check("pass_n_valid", DATA_WD'(iq_to_is_valid), '0);
    cycle(1'b1, DATA_WD'('h3C), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("pass_n1_valid", DATA_WD'(iq_to_is_valid), DATA_WD'(1));
    check("pass_n1_head",  iq_to_is_bus, DATA_WD'('h3C));
    pop();
    check("pass_n2_valid", DATA_WD'(iq_to_is_valid), '0);

    // Reset mid-operation together with enq and deq
    for (int i = 0; i < 4; i++) push(DATA_WD'('h70 + i));
    cycle(1'b1, DATA_WD'('h99), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("mrst_allowin", DATA_WD'(IQ_allowin), DATA_WD'(1));
    check("mrst_valid",   DATA_WD'(iq_to_is_valid), '0);
    check("mrst_bus",     iq_to_is_bus, '0);
    check("mrst_count",   DATA_WD'(iq_count), '0);
    push(DATA_WD'('h11));
    check("mrst_only", iq_to_is_bus, DATA_WD'('h11));
    pop();
    check("mrst_empty", DATA_WD'(iq_count), '0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rnd = '0;
      for (int k = 0; k < 6; k++) rnd[k*32 +: 32] = $urandom;
      rnd[DATA_WD-1:192] = 20'($urandom);
      cycle(($urandom_range(0, 9) < 7), rnd,
            ($urandom_range(0, 99) < 15),
            ($urandom_range(0, 99) < 3),
            ($urandom_range(0, 99) < 3),
            ($urandom_range(0, 9) < 5),
            ($urandom_range(0, 99) < 1));
    end
    check_model();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
